// File: rtl/crossfader_ramped_pkg.sv
// Shared types and gain helpers for the ramped crossfader.
// Widths here describe the default build; modules take their own parameters.
package crossfader_pkg;

    localparam int unsigned DWIDTH_DEF   = 16;
    localparam int unsigned CHANNELS_DEF = 2;
    localparam int unsigned LWIDTH_DEF   = 8;

    typedef logic signed [DWIDTH_DEF-1:0] sample_t;
    typedef sample_t [CHANNELS_DEF-1:0]   chan_bus_t;

    function automatic int unsigned level_full_scale(int unsigned lwidth);
        return 32'd1 << lwidth;
    endfunction

    // Returns {g1, g2}, each 32 bits; g1 + g2 always equals full scale.
    function automatic logic [63:0] gain_pair(int unsigned lwidth, int unsigned level);
        int unsigned g1;
        int unsigned g2;
        g2 = level;
        g1 = level_full_scale(lwidth) - level;
        return {g1, g2};
    endfunction

endpackage

// File: rtl/crossfader_ramped_if.sv
// Sample/level bus between the effect chain and the crossfader.
interface crossfader_ramped_if #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned LWIDTH   = 8
);
    logic                         valid_i;
    logic [CHANNELS*DWIDTH-1:0]   data_1_i;
    logic [CHANNELS*DWIDTH-1:0]   data_2_i;
    logic [LWIDTH-1:0]            level_i;
    logic                         cut_i;
    logic                         valid_o;
    logic [CHANNELS*DWIDTH-1:0]   data_o;
    logic [LWIDTH-1:0]            level_o;
    logic                         ramp_busy_o;

    modport master (
        output valid_i, data_1_i, data_2_i, level_i, cut_i,
        input  valid_o, data_o, level_o, ramp_busy_o
    );

    modport slave (
        input  valid_i, data_1_i, data_2_i, level_i, cut_i,
        output valid_o, data_o, level_o, ramp_busy_o
    );
endinterface

// File: rtl/crossfader_ramped_level_ramp.sv
// Slews the applied level toward the requested target once per accepted sample.
module crossfader_level_ramp #(
    parameter int unsigned LWIDTH    = 8,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              valid_i,
    input  logic [LWIDTH-1:0] level_i,
    input  logic              cut_i,
    output logic [LWIDTH-1:0] cur_level_o,
    output logic              ramp_busy_o
);

    localparam logic [LWIDTH:0] STEP = (LWIDTH+1)'(RAMP_STEP);

    logic [LWIDTH-1:0]        cur_q;
    logic [LWIDTH-1:0]        cur_d;
    logic signed [LWIDTH:0]   diff;
    logic [LWIDTH:0]          mag;

    // Stepping only happens when the gap exceeds STEP, so it cannot wrap.
    always_comb begin
        diff  = $signed({1'b0, level_i}) - $signed({1'b0, cur_q});
        mag   = diff[LWIDTH] ? $unsigned(-diff) : $unsigned(diff);
        cur_d = cur_q;
        if (valid_i) begin
            if (cut_i || (mag <= STEP)) begin
                cur_d = level_i;
            end else if (diff[LWIDTH]) begin
                cur_d = cur_q - STEP[LWIDTH-1:0];
            end else begin
                cur_d = cur_q + STEP[LWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            cur_q <= '0;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign cur_level_o = cur_q;
    assign ramp_busy_o = (cur_q != level_i);

endmodule

// File: rtl/crossfader_ramped.sv
// Two-stage multichannel crossfader sharing one slewed level across channels.
module crossfader_ramped
    import crossfader_pkg::*;
#(
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned LWIDTH    = 8,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic                 clk_i,
    input  logic                 srst_n_i,
    crossfader_ramped_if.slave   bus
);

    localparam int unsigned AW = DWIDTH + LWIDTH + 2;

    logic [LWIDTH-1:0]          cur_level;
    logic [63:0]                gains;
    logic [LWIDTH:0]            g1;
    logic [LWIDTH:0]            g2;
    logic [2*(31-LWIDTH)-1:0]   gains_unused;
    logic                       v1_q;
    logic                       v2_q;

    crossfader_level_ramp #(
        .LWIDTH    (LWIDTH),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk_i       (clk_i),
        .srst_n_i    (srst_n_i),
        .valid_i     (bus.valid_i),
        .level_i     (bus.level_i),
        .cut_i       (bus.cut_i),
        .cur_level_o (cur_level),
        .ramp_busy_o (bus.ramp_busy_o)
    );

    assign gains        = gain_pair(LWIDTH, 32'(cur_level));
    assign g1           = gains[32 +: LWIDTH+1];
    assign g2           = gains[0 +: LWIDTH+1];
    assign gains_unused = {gains[63:33+LWIDTH], gains[31:LWIDTH+1]};

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= bus.valid_i;
            v2_q <= v1_q;
        end
    end

    assign bus.valid_o = v2_q;
    assign bus.level_o = cur_level;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [DWIDTH-1:0] d1;
        logic signed [DWIDTH-1:0] d2;
        logic signed [AW-1:0]     p1_d;
        logic signed [AW-1:0]     p2_d;
        logic signed [AW-1:0]     p1_q;
        logic signed [AW-1:0]     p2_q;
        logic signed [AW-1:0]     sum;
        logic signed [DWIDTH-1:0] out_d;
        logic signed [DWIDTH-1:0] out_q;
        logic [LWIDTH+1:0]        sum_unused;

        assign d1   = bus.data_1_i[c*DWIDTH +: DWIDTH];
        assign d2   = bus.data_2_i[c*DWIDTH +: DWIDTH];
        assign p1_d = $signed({{(AW-DWIDTH){d1[DWIDTH-1]}}, d1})
                    * $signed({{(AW-LWIDTH-1){1'b0}}, g1});
        assign p2_d = $signed({{(AW-DWIDTH){d2[DWIDTH-1]}}, d2})
                    * $signed({{(AW-LWIDTH-1){1'b0}}, g2});

        // Taking the bit field above LWIDTH is the floor (arithmetic) shift.
        assign sum        = p1_q + p2_q;
        assign out_d      = sum[LWIDTH +: DWIDTH];
        assign sum_unused = {sum[AW-1 -: 2], sum[LWIDTH-1:0]};

        always_ff @(posedge clk_i) begin
            if (!srst_n_i) begin
                p1_q  <= '0;
                p2_q  <= '0;
                out_q <= '0;
            end else begin
                if (bus.valid_i) begin
                    p1_q <= p1_d;
                    p2_q <= p2_d;
                end
                if (v1_q) begin
                    out_q <= out_d;
                end
            end
        end

        assign bus.data_o[c*DWIDTH +: DWIDTH] = out_q;
    end

endmodule
